// File: rtl/scroll_seg_display.sv
// -----------------------------------------------------------------------------
// scroll_seg_display
//
// Scrolling 4-digit seven-segment banner core. A 4-character window slides over
// the fixed message 0,1,...,9. Each qualified scroll strobe moves the window
// start position one step left or right, wrapping between 0 and MAX_POS. A
// free-running refresh counter time-multiplexes the four decoded digits onto
// one shared segment bus.
//
// Parameters
//   MAX_POS       highest window start position (MAX_POS+3 <= 9)
//   REFRESH_BITS  refresh counter width; its top two bits pick the active digit
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high reset
//   en     in   scroll enable; 0 freezes the window
//   dir    in   1 = position increments, 0 = position decrements
//   tick   in   one-clk-wide scroll strobe
//   an     out  [3:0] digit anodes, active-low, exactly one low
//   sseg   out  [7:0] segments {dp,g,f,e,d,c,b,a}, active-low
//
// Optional feature (compile-time macro SCROLL_DIR_DP_EN)
//   Defined:   dir=1 lights the dp of digit0, dir=0 lights the dp of digit3.
//   Undefined: every decimal point stays off.
// -----------------------------------------------------------------------------
module scroll_seg_display #(
  parameter int MAX_POS      = 6,
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       tick,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  localparam logic [2:0] MAX_POS_L = 3'(MAX_POS);

  logic [2:0]              pos;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [1:0]              sel;
  logic [3:0]              digit_val [4];
  logic [3:0]              dp;
  logic [3:0]              cur_val;
  logic                    cur_dp;

  // Hex to seven-segment, active-low, bit order g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
    logic [6:0] seg;
    case (val)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'ha: seg = 7'b0001000;
      4'hb: seg = 7'b0000011;
      4'hc: seg = 7'b1000110;
      4'hd: seg = 7'b0100001;
      4'he: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Scroll position. Reset wins over a coincident strobe.
  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values;
  // blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos <= 3'd0;
    end else if (tick && en) begin
      if (dir) pos <= (pos == MAX_POS_L) ? 3'd0 : pos + 3'd1;
      else     pos <= (pos == 3'd0) ? MAX_POS_L : pos - 3'd1;
    end
  end

  // Free-running refresh counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) refresh_cnt <= '0;
    else       refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
  end

  assign sel = refresh_cnt[REFRESH_BITS-1:REFRESH_BITS-2];

  // Window: message[i] = i, so digit k simply shows pos+k.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      digit_val[k] = {1'b0, pos} + 4'(k);
    end
  end

`ifdef SCROLL_DIR_DP_EN
  // The lit decimal point sits on the side the text is moving toward.
  assign dp = {~dir, 2'b00, dir};
`else
  assign dp = 4'b0000;
`endif

  // Display mux: one anode low per refresh phase.
  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    an      = 4'b1110;
    cur_val = digit_val[0];
    cur_dp  = dp[0];
    case (sel)
      2'd1: begin
        an      = 4'b1101;
        cur_val = digit_val[1];
        cur_dp  = dp[1];
      end
      2'd2: begin
        an      = 4'b1011;
        cur_val = digit_val[2];
        cur_dp  = dp[2];
      end
      2'd3: begin
        an      = 4'b0111;
        cur_val = digit_val[3];
        cur_dp  = dp[3];
      end
      default: ;
    endcase
  end

  assign sseg = {~cur_dp, hex_to_seg(cur_val)};

endmodule

// File: tb/tb_scroll_seg_display.sv
// -----------------------------------------------------------------------------
// tb_scroll_seg_display
//
// Directed self-checking bench for scroll_seg_display, built with a 4-bit
// refresh counter so that one full refresh cycle takes 16 clocks. Inputs change
// 1 time unit after a rising edge; outputs are sampled at the same point.
// Define SCROLL_DIR_DP_EN here as well as in the RTL to check the dp feature.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scroll_seg_display;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       dir;
  logic       tick;
  logic [3:0] an;
  logic [7:0] sseg;

  int total = 0;
  int bad   = 0;

  // Active-low patterns for characters 0..9 with dp off.
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [3:0] an_tab  [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  scroll_seg_display #(
    .MAX_POS     (6),
    .REFRESH_BITS(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .dir  (dir),
    .tick (tick),
    .an   (an),
    .sseg (sseg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected segment byte for digit k at window position p under current dir.
  function automatic logic [7:0] exp_seg(input int p, input int k);
    logic [7:0] s;
    s = seg_tab[p + k];
`ifdef SCROLL_DIR_DP_EN
    if ((dir && k == 0) || (!dir && k == 3)) s[7] = 1'b0;
`endif
    return s;
  endfunction

  // Walk one full refresh cycle and check every digit shown for position p.
  task automatic check_window(input int p, input string name);
    int k;
    for (int c = 0; c < 16; c++) begin
      case (an)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        default: k = -1;
      endcase
      total++;
      if (k < 0) begin
        bad++;
        $display("FAIL %s an_onehot: got an=%b, need one low bit", name, an);
      end else if (sseg !== exp_seg(p, k)) begin
        bad++;
        $display("FAIL %s pos%0d digit%0d: got sseg=%h, need %h",
                 name, p, k, sseg, exp_seg(p, k));
      end
      step();
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; dir = 1'b1; tick = 1'b0;
    repeat (3) step();
    total++;
    if (an !== 4'b1110 || sseg !== exp_seg(0, 0)) begin
      bad++;
      $display("FAIL reset_out: got an=%b sseg=%h, need an=1110 sseg=%h",
               an, sseg, exp_seg(0, 0));
    end
    reset = 1'b0;
    // Counter starts at 0: four clocks per anode phase, in order.
    for (int c = 0; c < 16; c++) begin
      total++;
      if (an !== an_tab[c / 4] || sseg !== exp_seg(0, c / 4)) begin
        bad++;
        $display("FAIL refresh_c%0d: got an=%b sseg=%h, need an=%b sseg=%h",
                 c, an, sseg, an_tab[c / 4], exp_seg(0, c / 4));
      end
      step();
    end
  endtask

  task automatic test_scroll_up();
    int exp_pos [7] = '{1, 2, 3, 4, 5, 6, 0};
    en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pulse_tick();
      check_window(exp_pos[i], "scroll_up");
    end
  endtask

  task automatic test_scroll_down();
    en = 1'b1; dir = 1'b0;
    pulse_tick();
    check_window(6, "down_wrap");
    pulse_tick();
    check_window(5, "down_step");
  endtask

  task automatic test_hold();
    en = 1'b0;
    repeat (5) pulse_tick();
    check_window(5, "hold_en0");
    en = 1'b1; tick = 1'b0;
    repeat (20) step();
    check_window(5, "hold_notick");
  endtask

  task automatic test_reset_priority();
    en = 1'b1; dir = 1'b0;
    pulse_tick();
    check_window(4, "pre_reset");
    // Let the counter sit away from zero so the reset visibly clears it.
    repeat (5) step();
    reset = 1'b1; tick = 1'b1;
    step();
    reset = 1'b0; tick = 1'b0;
    total++;
    if (an !== 4'b1110 || sseg !== exp_seg(0, 0)) begin
      bad++;
      $display("FAIL reset_vs_tick: got an=%b sseg=%h, need an=1110 sseg=%h",
               an, sseg, exp_seg(0, 0));
    end
    repeat (4) step();
    total++;
    if (an !== 4'b1101) begin
      bad++;
      $display("FAIL reset_counter: got an=%b, need 1101", an);
    end
    repeat (12) step();
    check_window(0, "post_reset");
  endtask

  task automatic test_dir_dp();
    en = 1'b0;
    dir = 1'b1;
    step();
    check_window(0, "dp_dir1");
    dir = 1'b0;
    step();
    check_window(0, "dp_dir0");
  endtask

  initial begin
    test_reset();
    test_scroll_up();
    test_scroll_down();
    test_hold();
    test_reset_priority();
    test_dir_dp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
